// File: rtl/xmul_dot_acc.sv
// Streaming dot-product accumulator: sums termN signed products per frame, then
// rounds, scales and saturates the sum into a one-entry valid/ready output register.
module xmul_dot_acc #(
  parameter int dataW  = 8,
  parameter int termN  = 9,
  parameter int accW   = dataW + $clog2(termN),
  parameter int shiftR = 2,
  parameter int outW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dataW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [outW-1:0]  out_data,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(termN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(termN - 1);
  // Half an LSB of the scaled result; zero when no shift is applied.
  localparam logic signed [accW:0] RND   = (accW + 1)'((2 ** shiftR) / 2);
  localparam logic signed [accW:0] Q_MAX = (accW + 1)'((2 ** (outW - 1)) - 1);
  localparam logic signed [accW:0] Q_MIN = (accW + 1)'(-(2 ** (outW - 1)));

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [accW-1:0]  acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [outW-1:0]         out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    last_term;
  logic                    accept;
  logic                    drain;
  logic signed [accW-1:0]  in_ext;
  logic signed [accW-1:0]  sum;
  logic signed [accW:0]    rounded;
  logic signed [accW:0]    scaled;

  always_comb begin
    last_term = (cnt_q == CNT_LAST);
    // Only the closing term waits, and only while an undrained result is held.
    in_ready  = !(last_term && out_valid_q && !out_ready);
    accept    = in_valid && in_ready;
    drain     = out_valid_q && out_ready;

    in_ext  = accW'($signed(in_data));
    sum     = acc_q + in_ext;
    rounded = (accW + 1)'(sum) + RND;
    scaled  = rounded >>> shiftR;

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      cnt_d = last_term ? '0 : cnt_q + CNT_W'(1);
      acc_d = (cnt_q == '0) ? in_ext : sum;
    end

    // A closing frame overrides a simultaneous drain so the register never bubbles.
    if (accept && last_term) begin
      out_valid_d = 1'b1;
      if (scaled > Q_MAX) begin
        out_data_d = Q_MAX[outW-1:0];
        out_sat_d  = 1'b1;
      end else if (scaled < Q_MIN) begin
        out_data_d = Q_MIN[outW-1:0];
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = scaled[outW-1:0];
        out_sat_d  = 1'b0;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/xmul_dot_acc.md
# xmul_dot_acc

Streaming dot-product accumulator that sits directly downstream of the approximate signed multiplier in the SIFT filter datapath. It consumes one signed product per accepted handshake and sums a fixed frame of `termN` products, one frame per kernel tap window. At the end of each frame it rounds, scales and saturates the sum and presents it through a one-entry output register with valid/ready back-pressure.

## Interface
- `dataW`, 8: signed product width, equal to the multiplier `outW`.
- `termN`, 9: products per frame (kernel taps); ≥2.
- `accW`, `dataW+$clog2(termN)`: signed accumulator width; never overflows internally.
- `shiftR`, 2: arithmetic right shift applied to the frame sum; 0 allowed.
- `outW`, 8: signed result width.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `in_data` in `dataW`: signed product from the multiplier.
- `out_valid` out 1: `out_data` and `out_sat` hold a frame result.
- `out_ready` in 1: the consumer takes the result this cycle.
- `out_data` out `outW`: signed, rounded, saturated frame result.
- `out_sat` out 1: `out_data` was clamped.

## Operation
- Accept: `in_valid && in_ready` on a rising edge.
- Drain: `out_valid && out_ready` on a rising edge.
- Term counter `cnt` runs 0..`termN-1`. It increments on each accept and wraps to 0 on the accept of term `termN-1`.
- Accumulator update on accept:
  - `acc <= in_data` (sign-extended) when `cnt==0`.
  - `acc <= acc + in_data` otherwise.
  - `acc` holds when there is no accept.
- Frame close, on accept with `cnt==termN-1`:
  - `sum = acc + in_data`, computed in `accW` bits.
  - `r = sum + 2^(shiftR-1)` when `shiftR>0`, else `r = sum`. `r` is computed in `accW+1` bits (round half toward +inf).
  - `q = r >>> shiftR`, arithmetic shift.
  - `out_data <= clamp(q, -2^(outW-1), 2^(outW-1)-1)`.
  - `out_sat <= 1` if clamped, else 0.
  - `out_valid <= 1`.
- Output register update on a rising edge:
  - Loaded on frame close.
  - Otherwise `out_valid <= 0` on drain; `out_data` and `out_sat` hold their last values.
  - Frame close and drain in the same cycle: the new result replaces the old one and `out_valid` stays 1. No bubble, no loss.
- `in_ready = !(cnt==termN-1 && out_valid && !out_ready)`.
  - Only the closing term stalls, and only while an undrained result occupies the register.
  - Terms 0..`termN-2` of the next frame are always accepted.
- Backpressure never drops or duplicates a result; results leave in frame order.
- Reset, at any time including mid-frame: `cnt=0`, `acc=0`, `out_valid=0`, `out_data=0`, `out_sat=0`, `in_ready=1`. The partial frame is discarded.
- `in_valid` low mid-frame pauses accumulation indefinitely with no timeout.

## Timing
- Latency: the closing term accepted at edge t gives `out_valid=1` immediately after edge t, sampled by the consumer at edge t+1.
- Throughput: one term per cycle sustained while `out_ready` stays high; one result every `termN` accepts.
- `in_ready` is combinational from `cnt`, `out_valid` and `out_ready`. There is no combinational path from `in_valid` or `in_data` to any output.
- All outputs other than `in_ready` are registered.

## Test plan
- Basic sum: with defaults and `out_ready=1`, nine terms of 10 give sum 90 → (90+2)>>>2 = 23. Required: `out_data=23`, `out_sat=0`, `out_valid` one cycle after the 9th accept, for exactly one cycle.
- Saturation:
  - Nine terms of 127 give sum 1143 → q=286 → `out_data=127`, `out_sat=1`.
  - Nine terms of -128 give sum -1152 → q=-288 → `out_data=-128`, `out_sat=1`.
- Rounding: frames with sums 3, 2, -2 and -3 (remaining terms 0) give `out_data` 1, 1, 0 and -1 respectively.
- Backpressure: hold `out_ready=0` after frame A = nine terms of 4 (result 9), then stream frame B = nine terms of 8.
  - Required: eight B terms accepted, `in_ready=0` on B's 9th term.
  - Raising `out_ready` drains 9 and accepts B's 9th term in the same cycle.
  - Next result is 18.
- Reset mid-frame: accept 4 terms of 50, pulse `rst`, then nine terms of 5. Required: all outputs 0 during reset, and a single result of (45+2)>>>2 = 11.
- Streaming: 27 consecutive terms with values 1..27, `out_ready=1`, no gaps. Required: `in_ready` never drops, and results are (45+2)>>>2=11, (126+2)>>>2=32 and (207+2)>>>2=52.
